// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared widths and the write-back entry type
package npc_pkg;

    localparam int NPC_WIDTH      = 32;
    localparam int NPC_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [NPC_ADDR_WIDTH-1:0] rd;
        logic [NPC_WIDTH-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// rtl/wb_match.sv - youngest-match search over the queued write-back entries
module wb_match #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic [DEPTH*ADDR_WIDTH-1:0] rd_flat,
    input  logic [DEPTH*WIDTH-1:0]      data_flat,
    input  logic [PTR_W-1:0]            head,
    input  logic [PTR_W:0]              count,
    input  logic [ADDR_WIDTH-1:0]       q,
    output logic                        hit,
    output logic [WIDTH-1:0]            d
);

    // Walk oldest to youngest so a later match overwrites an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit = 1'b0;
        d   = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (q != '0) &&
                (rd_flat[idx*ADDR_WIDTH +: ADDR_WIDTH] == q)) begin
                hit = 1'b1;
                d   = data_flat[idx*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// rtl/wb_buffer.sv - in-order write-back queue with register file drain and bypass lookup
module wb_buffer
    import npc_pkg::*;
#(
    parameter int WIDTH      = NPC_WIDTH,
    parameter int ADDR_WIDTH = NPC_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [WIDTH-1:0]      lsu_data,
    input  logic                  hold,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addrw,
    output logic [WIDTH-1:0]      dinw,
    input  logic [ADDR_WIDTH-1:0] qa,
    input  logic [ADDR_WIDTH-1:0] qb,
    output logic                  hita,
    output logic                  hitb,
    output logic [WIDTH-1:0]      da,
    output logic [WIDTH-1:0]      db,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;

    logic [PTR_W:0]     free;
    logic               lsu_push, alu_push, deq;
    logic [PTR_W-1:0]   alu_idx;
    logic [1:0]         enq_cnt;

    logic [DEPTH*ADDR_WIDTH-1:0] rd_flat;
    logic [DEPTH*WIDTH-1:0]      data_flat;
    logic                        hit_a_raw, hit_b_raw;
    logic [WIDTH-1:0]            d_a_raw, d_b_raw;

    // Readiness uses start-of-cycle occupancy only; a load with rd==0 takes no slot.
    always_comb begin
        free      = (PTR_W+1)'(DEPTH) - count_q;
        lsu_ready = !rst && (free != '0);
        if (lsu_valid && (lsu_rd != '0))
            alu_ready = !rst && (free > (PTR_W+1)'(1));
        else
            alu_ready = !rst && (free != '0);

        lsu_push = lsu_valid && lsu_ready && (lsu_rd != '0);
        alu_push = alu_valid && alu_ready && (alu_rd != '0);
        deq      = !rst && (count_q != '0) && !hold;

        alu_idx  = tail_q + PTR_W'(lsu_push);
        enq_cnt  = {1'b0, lsu_push} + {1'b0, alu_push};

        mem_d = mem_q;
        if (lsu_push) begin
            mem_d[tail_q].rd   = lsu_rd;
            mem_d[tail_q].data = lsu_data;
        end
        if (alu_push) begin
            mem_d[alu_idx].rd   = alu_rd;
            mem_d[alu_idx].data = alu_data;
        end

        tail_d  = tail_q + PTR_W'(enq_cnt);
        head_d  = head_q + PTR_W'(deq);
        count_d = count_q + (PTR_W+1)'(enq_cnt) - (PTR_W+1)'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    always_comb begin
        rd_flat   = '0;
        data_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_flat[i*ADDR_WIDTH +: ADDR_WIDTH] = mem_q[i].rd;
            data_flat[i*WIDTH +: WIDTH]         = mem_q[i].data;
        end
    end

    wb_match #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_match_a (
        .rd_flat   (rd_flat),
        .data_flat (data_flat),
        .head      (head_q),
        .count     (count_q),
        .q         (qa),
        .hit       (hit_a_raw),
        .d         (d_a_raw)
    );

    wb_match #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_match_b (
        .rd_flat   (rd_flat),
        .data_flat (data_flat),
        .head      (head_q),
        .count     (count_q),
        .q         (qb),
        .hit       (hit_b_raw),
        .d         (d_b_raw)
    );

    always_comb begin
        we    = deq;
        addrw = rst ? '0 : mem_q[head_q].rd;
        dinw  = rst ? '0 : mem_q[head_q].data;
        hita  = !rst && hit_a_raw;
        hitb  = !rst && hit_b_raw;
        da    = rst ? '0 : d_a_raw;
        db    = rst ? '0 : d_b_raw;
        empty = rst || (count_q == '0);
    end

endmodule

// File: tb/tb_wb_buffer.sv
// tb/tb_wb_buffer.sv - scoreboard bench for wb_buffer
module tb_wb_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, hold;
    logic [4:0]  alu_rd, lsu_rd, qa, qb;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, we, hita, hitb, empty;
    logic [4:0]  addrw;
    logic [31:0] dinw, da, db;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_buffer #(.WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .hold      (hold),
        .we        (we),
        .addrw     (addrw),
        .dinw      (dinw),
        .qa        (qa),
        .qb        (qb),
        .hita      (hita),
        .hitb      (hitb),
        .da        (da),
        .db        (db),
        .empty     (empty)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] lookup(input logic [4:0] q);
        logic [32:0] r;
        r = '0;
        for (int i = 0; i < sb.size(); i++)
            if (q != 5'd0 && sb[i].rd == q) r = {1'b1, sb[i].data};
        return r;
    endfunction

    // Model reference: checks outputs against start-of-cycle state, then advances it.
    always @(negedge clk) begin
        int          size;
        int          free;
        logic        exp_lsu, exp_alu, exp_we;
        logic [32:0] la, lb;
        ent_t        e;
        size = sb.size();
        free = DEPTH - size;
        if (rst) begin
            check_eq("rst_lsu_ready", 64'(lsu_ready), 64'd0);
            check_eq("rst_alu_ready", 64'(alu_ready), 64'd0);
            check_eq("rst_we",        64'(we),        64'd0);
            check_eq("rst_addrw",     64'(addrw),     64'd0);
            check_eq("rst_dinw",      64'(dinw),      64'd0);
            check_eq("rst_hit",       64'({hita, hitb}), 64'd0);
            check_eq("rst_d",         {da, db},       64'd0);
            check_eq("rst_empty",     64'(empty),     64'd1);
            sb.delete();
        end else begin
            exp_lsu = (free >= 1);
            exp_alu = (lsu_valid && lsu_rd != 5'd0) ? (free >= 2) : (free >= 1);
            exp_we  = (size != 0) && !hold;
            la = lookup(qa);
            lb = lookup(qb);
            check_eq("lsu_ready", 64'(lsu_ready), 64'(exp_lsu));
            check_eq("alu_ready", 64'(alu_ready), 64'(exp_alu));
            check_eq("empty",     64'(empty),     64'(size == 0));
            check_eq("hita",      64'(hita),      64'(la[32]));
            check_eq("hitb",      64'(hitb),      64'(lb[32]));
            if (la[32]) check_eq("da", 64'(da), 64'(la[31:0]));
            if (lb[32]) check_eq("db", 64'(db), 64'(lb[31:0]));
            check_eq("we", 64'(we), 64'(exp_we));
            if (exp_we) begin
                e = sb.pop_front();
                check_eq("addrw", 64'(addrw), 64'(e.rd));
                check_eq("dinw",  64'(dinw),  64'(e.data));
            end
            if (lsu_valid && exp_lsu && lsu_rd != 5'd0) begin
                e.rd = lsu_rd; e.data = lsu_data;
                sb.push_back(e);
            end
            if (alu_valid && exp_alu && alu_rd != 5'd0) begin
                e.rd = alu_rd; e.data = alu_data;
                sb.push_back(e);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad);
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        alu_valid = av; alu_rd = ard; alu_data = ad;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; qa = 5'd0; qb = 5'd0;
        idle();
        step(2);
        rst = 1'b0;
        step(1);

        // single ALU write drains next cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
        step(1); idle(); qa = 5'd3;
        step(3);

        // dual accept: load older than ALU; bypass sees youngest
        qa = 5'd5; qb = 5'd5;
        drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        step(1); idle();
        step(3);

        // hold with a full queue, then release
        hold = 1'b1; qa = 5'd2; qb = 5'd4;
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102); step(1);
        drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104); step(1);
        drive(1'b1, 5'd9, 32'h999, 1'b1, 5'd9, 32'h998); step(2);
        idle(); hold = 1'b0;
        step(6);

        // rd==0 completes handshake but is never written or matched
        qa = 5'd0;
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h56); step(1);
        idle(); step(3);

        // free==1 with both valid: load wins, ALU follows
        hold = 1'b1;
        drive(1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7); step(1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h8); step(1);
        hold = 1'b0;
        drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA); step(1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA); step(1);
        idle(); step(6);

        // reset mid-operation discards queued entries
        hold = 1'b1; qa = 5'd11;
        drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hB2); step(1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hB3); step(1);
        idle(); rst = 1'b1; step(1);
        rst = 1'b0; hold = 1'b0; step(4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            hold = ($urandom_range(0, 3) == 0);
            qa   = 5'($urandom_range(0, 7));
            qb   = 5'($urandom_range(0, 7));
            rst  = ($urandom_range(0, 99) == 0);
            step(1);
        end
        idle(); hold = 1'b0; rst = 1'b0;
        step(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
